// File: rtl/piano_roll_sequencer_pkg.sv
// rtl/piano_roll_sequencer_pkg.sv - sequencer state encoding and note-word field layout
package piano_roll_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    PLAY   = 2'd3
  } seq_state_t;

  localparam int REST_NOTE = 0;

  // Word layout is {end_flag, note, dur}, MSB first.
  function automatic int end_bit(input int note_w, input int dur_w);
    return note_w + dur_w;
  endfunction

  function automatic int note_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int dur_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/piano_seq_tick_gen.sv
// rtl/piano_seq_tick_gen.sv - tempo divider, one tick pulse every TICK_DIV clocks
module piano_seq_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/piano_roll_sequencer.sv
// rtl/piano_roll_sequencer.sv - walks the note-event RAM and holds each note for dur tempo ticks
// Optional internal tempo divider: PIANO_SEQ_TICK_GEN_EN.
module piano_roll_sequencer
  import piano_roll_sequencer_pkg::*;
#(
  parameter  int ADDR_W   = 8,
  parameter  int NOTE_W   = 7,
  parameter  int DUR_W    = 8,
  parameter  int TICK_DIV = 50000,
  localparam int DATA_W   = 1 + NOTE_W + DUR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              tick,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_data,
  output logic              note_on,
  output logic [NOTE_W-1:0] note,
  output logic              busy,
  output logic              done
);

  localparam int END_BIT  = end_bit(NOTE_W, DUR_W);
  localparam int NOTE_LSB = note_lsb(DUR_W);
  localparam int DUR_LSB  = dur_lsb();

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic              note_on_d, done_d;
  logic [NOTE_W-1:0] note_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic              tick_en;

  logic              end_flag;
  logic [NOTE_W-1:0] note_field;
  logic [DUR_W-1:0]  dur_field;
  logic              at_top;

  assign end_flag   = ram_data[END_BIT];
  assign note_field = ram_data[NOTE_LSB +: NOTE_W];
  assign dur_field  = ram_data[DUR_LSB +: DUR_W];
  assign at_top     = (ram_addr == {ADDR_W{1'b1}});

`ifdef PIANO_SEQ_TICK_GEN_EN
  logic unused_tick;
  assign unused_tick = tick;

  piano_seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == IDLE),
    .tick (tick_en)
  );
`else
  logic unused_tick_div;
  assign unused_tick_div = (TICK_DIV != 0);
  assign tick_en         = tick;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ram_addr <= '0;
      note_on  <= 1'b0;
      note     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ram_addr <= addr_d;
      note_on  <= note_on_d;
      note     <= note_d;
      busy     <= (state_d != IDLE);
      done     <= done_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = ram_addr;
    note_on_d = note_on;
    note_d    = note;
    cnt_d     = cnt_q;
    wrap_d    = wrap_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          addr_d  = '0;
          wrap_d  = 1'b0;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        // A pending address wrap is treated as an end word; the fetched data is ignored.
        if (wrap_q || end_flag) begin
          note_on_d = 1'b0;
          wrap_d    = 1'b0;
          if (loop_en) begin
            state_d = FETCH;
            addr_d  = '0;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (dur_field == '0) begin
          note_on_d = 1'b0;
          state_d   = FETCH;
          addr_d    = ram_addr + ADDR_W'(1);
          wrap_d    = at_top;
        end else begin
          state_d   = PLAY;
          note_d    = note_field;
          note_on_d = (note_field != NOTE_W'(REST_NOTE));
          cnt_d     = dur_field;
        end
      end
      PLAY: begin
        if (tick_en) begin
          cnt_d = cnt_q - DUR_W'(1);
          if (cnt_q == DUR_W'(1)) begin
            note_on_d = 1'b0;
            state_d   = FETCH;
            addr_d    = ram_addr + ADDR_W'(1);
            wrap_d    = at_top;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d   = IDLE;
      note_on_d = 1'b0;
      addr_d    = '0;
      wrap_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_piano_roll_sequencer.sv
// tb/tb_piano_roll_sequencer.sv - randomized and directed checks of piano_roll_sequencer against a song-level model
module tb_piano_roll_sequencer;

  localparam int AW     = 3;
  localparam int NW     = 7;
  localparam int DW     = 8;
  localparam int DATAW  = 1 + NW + DW;
  localparam int NWORDS = 1 << AW;
  localparam int BUDGET = 4000;

  logic             clk = 1'b0;
  logic             rst, start, stop, loop_en, tick;
  logic [AW-1:0]    ram_addr;
  logic [DATAW-1:0] ram_data;
  logic             note_on;
  logic [NW-1:0]    note;
  logic             busy, done;

  piano_roll_sequencer #(.ADDR_W(AW), .NOTE_W(NW), .DUR_W(DW), .TICK_DIV(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .tick     (tick),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .note_on  (note_on),
    .note     (note),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  logic [DATAW-1:0] mem [NWORDS];
  always @(posedge clk) ram_data <= mem[ram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observed sounding notes: number and ticks seen while the key was held.
  int obs_note[$], obs_dur[$];
  int done_cnt = 0, unstable = 0, cur_note = 0, cur_ticks = 0;
  bit prev_on = 1'b0;

  always @(negedge clk) begin
    if (note_on === 1'b1) begin
      if (!prev_on) begin
        cur_note  = int'(note);
        cur_ticks = 0;
      end else if (int'(note) != cur_note) begin
        unstable++;
      end
      if (tick === 1'b1) cur_ticks++;
    end else if (prev_on) begin
      obs_note.push_back(cur_note);
      obs_dur.push_back(cur_ticks);
    end
    prev_on = (note_on === 1'b1);
    if (done === 1'b1) done_cnt++;
  end

  int cyc = 0;
  bit rand_tick = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    stop  = 1'b0;
    tick  = rand_tick ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
  endtask

  function automatic logic [DATAW-1:0] word(input bit e, input int n, input int d);
    logic [NW-1:0] nn;
    logic [DW-1:0] dd;
    nn = NW'(n);
    dd = DW'(d);
    return {e, nn, dd};
  endfunction

  task automatic load3(input logic [DATAW-1:0] w0, input logic [DATAW-1:0] w1,
                       input logic [DATAW-1:0] w2);
    for (int i = 0; i < NWORDS; i++) mem[i] = word(1'b1, 0, 0);
    mem[0] = w0;
    mem[1] = w1;
    mem[2] = w2;
  endtask

  // Song-level model: sounding notes in play order and the address left at completion.
  int exp_note[$], exp_dur[$];
  int exp_end;

  task automatic build_expect(input bit lp);
    exp_note.delete();
    exp_dur.delete();
    for (int p = 0; p < (lp ? 3 : 1); p++) begin
      exp_end = 0;
      for (int a = 0; a < NWORDS; a++) begin
        logic [DATAW-1:0] w;
        w = mem[a];
        if (w[DATAW-1]) begin
          exp_end = a;
          break;
        end
        if (w[DW +: NW] != 0 && w[DW-1:0] != 0) begin
          exp_note.push_back(int'(w[DW +: NW]));
          exp_dur.push_back(int'(w[DW-1:0]));
        end
      end
    end
  endtask

  task automatic run_song(input string name, input bit lp);
    logic [DATAW-1:0] w0;
    bit first_sounds;
    int n;
    build_expect(lp);
    w0 = mem[0];
    first_sounds = !w0[DATAW-1] && (w0[DW +: NW] != 0) && (w0[DW-1:0] != 0);
    loop_en = lp;
    obs_note.delete();
    obs_dur.delete();
    done_cnt = 0;
    unstable = 0;
    start = 1'b1;
    step();
    step();
    check({name, ".note_on_c2"}, note_on, 1'b0);
    step();
    check({name, ".note_on_c3"}, note_on, first_sounds);
    n = 0;
    while (n < BUDGET) begin
      if (!lp && done_cnt > 0) break;
      if (lp && obs_note.size() >= exp_note.size()) break;
      start = busy && ($urandom_range(0, 15) == 0);
      step();
      n++;
    end
    check({name, ".timeout"}, n < BUDGET, 1'b1);
    if (lp) begin
      stop = 1'b1;
      step();
    end
    step();
    step();
    if (lp) check({name, ".n_notes"}, obs_note.size() >= exp_note.size(), 1'b1);
    else    check({name, ".n_notes"}, obs_note.size(), exp_note.size());
    for (int i = 0; i < exp_note.size() && i < obs_note.size(); i++) begin
      check($sformatf("%s.note%0d", name, i), obs_note[i], exp_note[i]);
      check($sformatf("%s.dur%0d", name, i), obs_dur[i], exp_dur[i]);
    end
    check({name, ".done_cnt"}, done_cnt, lp ? 0 : 1);
    check({name, ".busy_end"}, busy, 1'b0);
    check({name, ".stable"}, unstable, 0);
    if (!lp) check({name, ".end_addr"}, ram_addr, exp_end);
    stop = 1'b1;
    step();
  endtask

  task automatic play_until_note(input string name);
    start = 1'b1;
    step();
    for (int i = 0; i < 20 && note_on !== 1'b1; i++) step();
    check({name, ".reach_play"}, note_on, 1'b1);
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; tick = 1'b0;
    for (int i = 0; i < NWORDS; i++) mem[i] = word(1'b1, 0, 0);
    step();
    step();
    check("rst.addr", ram_addr, 0);
    check("rst.note_on", note_on, 0);
    check("rst.note", note, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    rst = 1'b0;
    step();

    rand_tick = 1'b0;
    load3(word(0, 60, 3), word(1, 0, 0), word(1, 0, 0));
    run_song("basic", 1'b0);
    load3(word(0, 0, 2), word(0, 64, 1), word(1, 0, 0));
    run_song("rest", 1'b0);
    load3(word(0, 62, 0), word(0, 65, 1), word(1, 0, 0));
    run_song("skip", 1'b0);
    load3(word(0, 60, 2), word(0, 67, 1), word(1, 0, 0));
    run_song("loop", 1'b1);
    for (int i = 0; i < NWORDS; i++) mem[i] = word(0, 40 + i, 1);
    run_song("wrap", 1'b0);

    load3(word(0, 60, 3), word(1, 0, 0), word(1, 0, 0));
    loop_en = 1'b0;
    play_until_note("stop");
    stop = 1'b1;
    step();
    check("stop.note_on", note_on, 0);
    check("stop.busy", busy, 0);
    check("stop.addr", ram_addr, 0);
    check("stop.done", done, 0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    check("startstop.busy", busy, 0);
    step();
    check("startstop.busy2", busy, 0);

    play_until_note("midrst");
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    check("midrst.note_on", note_on, 0);
    check("midrst.note", note, 0);
    check("midrst.busy", busy, 0);
    check("midrst.addr", ram_addr, 0);
    step();

    rand_tick = 1'b1;
    for (int t = 0; t < 20; t++) begin
      bit lp;
      lp = ($urandom_range(0, 2) == 0);
      for (int a = 0; a < NWORDS; a++)
        mem[a] = word($urandom_range(0, 7) == 0,
                      ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 127)),
                      int'($urandom_range(0, 3)));
      if (lp) mem[0] = word(0, int'($urandom_range(1, 127)), int'($urandom_range(1, 3)));
      run_song($sformatf("rnd%0d", t), lp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
